// File: rtl/csr_stream_bridge_pkg.sv
// ============================================================================
// csr_stream_bridge_pkg : shared register map and STATUS bit positions
// Rev 1.0
// ============================================================================
`default_nettype none

package csr_stream_bridge_pkg;

  localparam int c_csr_w  = 8;
  localparam int c_word_w = 16;

  // Register offsets within the bank (csr_adr[3:0])
  localparam logic [3:0] c_ofs_status    = 4'h0;
  localparam logic [3:0] c_ofs_rx_level  = 4'h1;
  localparam logic [3:0] c_ofs_rx_data_l = 4'h2;
  localparam logic [3:0] c_ofs_rx_data_h = 4'h3;
  localparam logic [3:0] c_ofs_tx_data_l = 4'h4;
  localparam logic [3:0] c_ofs_tx_data_h = 4'h5;
  localparam logic [3:0] c_ofs_ctrl      = 4'h6;
  localparam logic [3:0] c_ofs_tx_level  = 4'h7;

  // STATUS bit positions
  localparam int c_st_rx_empty = 0;
  localparam int c_st_rx_full  = 1;
  localparam int c_st_tx_empty = 2;
  localparam int c_st_tx_full  = 3;
  localparam int c_st_tx_ovf   = 4;

  // CTRL bit positions
  localparam int c_ctrl_rx_pop  = 0;
  localparam int c_ctrl_ovf_clr = 1;
  localparam int c_ctrl_flush   = 2;

endpackage

`default_nettype wire

// File: rtl/csr_stream_bridge_fifo_sync.sv
// ============================================================================
// fifo_sync : single-clock FIFO with level count and synchronous flush
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_sync #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full
);

  localparam int c_depth = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [c_depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_push;
  logic                  w_pop;

  assign empty  = (r_level == '0);
  assign full   = (r_level == (DEPTH_LOG2+1)'(c_depth));
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign level  = r_level;
  assign dout   = r_mem[r_rd_ptr];

  // Flush overrides any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/csr_stream_bridge.sv
// ============================================================================
// csr_stream_bridge : CSR-mapped rx/tx word FIFOs between GPMC host and datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module csr_stream_bridge
  import csr_stream_bridge_pkg::*;
#(
  parameter logic [3:0] BANK       = 4'h1,
  parameter int         DEPTH_LOG2 = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [13:0]          csr_adr,
  input  logic                 csr_we,
  input  logic [c_csr_w-1:0]   csr_dat_w,
  output logic [c_csr_w-1:0]   csr_dat_r,
  input  logic                 sink_stb,
  output logic                 sink_ack,
  input  logic [c_word_w-1:0]  sink_data,
  output logic                 src_stb,
  input  logic                 src_ack,
  output logic [c_word_w-1:0]  src_data
);

  logic                  w_sel;
  logic [3:0]            w_ofs;
  logic                  w_wr;
  logic                  w_ctrl_wr;
  logic                  w_tx_push;
  logic                  w_rx_pop;
  logic                  w_flush;
  logic                  w_ovf_set;
  logic                  w_ovf_clr;
  logic                  w_unused_adr;
  logic [c_word_w-1:0]   w_rx_head;
  logic [DEPTH_LOG2:0]   w_rx_level;
  logic [DEPTH_LOG2:0]   w_tx_level;
  logic                  w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic [c_csr_w-1:0]    w_status;
  logic [c_csr_w-1:0]    w_rd_data;
  logic [c_csr_w-1:0]    r_hold;
  logic                  r_tx_ovf;
  logic [c_csr_w-1:0]    r_dat_r;

  assign w_sel        = (csr_adr[13:10] == BANK);
  assign w_ofs        = csr_adr[3:0];
  assign w_unused_adr = ^csr_adr[9:4];
  assign w_wr         = csr_we & w_sel;
  assign w_ctrl_wr    = w_wr & (w_ofs == c_ofs_ctrl);
  assign w_tx_push    = w_wr & (w_ofs == c_ofs_tx_data_h);
  assign w_rx_pop     = w_ctrl_wr & csr_dat_w[c_ctrl_rx_pop];
  assign w_flush      = w_ctrl_wr & csr_dat_w[c_ctrl_flush];
  assign w_ovf_clr    = w_ctrl_wr & csr_dat_w[c_ctrl_ovf_clr];
  assign w_ovf_set    = w_tx_push & w_tx_full;

  assign sink_ack  = ~w_rx_full;
  assign src_stb   = ~w_tx_empty;
  assign csr_dat_r = r_dat_r;

  fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(c_word_w)) u_rx_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .push  (sink_stb),
    .pop   (w_rx_pop),
    .flush (w_flush),
    .din   (sink_data),
    .dout  (w_rx_head),
    .level (w_rx_level),
    .empty (w_rx_empty),
    .full  (w_rx_full)
  );

  fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(c_word_w)) u_tx_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .push  (w_tx_push),
    .pop   (src_ack),
    .flush (w_flush),
    .din   ({csr_dat_w, r_hold}),
    .dout  (src_data),
    .level (w_tx_level),
    .empty (w_tx_empty),
    .full  (w_tx_full)
  );

  always_comb begin
    w_status                = '0;
    w_status[c_st_rx_empty] = w_rx_empty;
    w_status[c_st_rx_full]  = w_rx_full;
    w_status[c_st_tx_empty] = w_tx_empty;
    w_status[c_st_tx_full]  = w_tx_full;
    w_status[c_st_tx_ovf]   = r_tx_ovf;
  end

  // RX_DATA reads return zero rather than stale memory when rx is empty
  always_comb begin
    w_rd_data = '0;
    if (w_sel) begin
      case (w_ofs)
        c_ofs_status:    w_rd_data = w_status;
        c_ofs_rx_level:  w_rd_data = c_csr_w'(w_rx_level);
        c_ofs_rx_data_l: w_rd_data = w_rx_empty ? '0 : w_rx_head[7:0];
        c_ofs_rx_data_h: w_rd_data = w_rx_empty ? '0 : w_rx_head[15:8];
        c_ofs_tx_level:  w_rd_data = c_csr_w'(w_tx_level);
        default:         w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_hold   <= '0;
      r_tx_ovf <= 1'b0;
      r_dat_r  <= '0;
    end else begin
      r_dat_r <= w_rd_data;
      if (w_flush)
        r_hold <= '0;
      else if (w_wr && (w_ofs == c_ofs_tx_data_l))
        r_hold <= csr_dat_w;
      // A same-cycle overflow wins over the clear
      if (w_ovf_set)
        r_tx_ovf <= 1'b1;
      else if (w_ovf_clr)
        r_tx_ovf <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csr_stream_bridge.sv
// ============================================================================
// tb_csr_stream_bridge : table-driven CSR vectors plus directed stream sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_csr_stream_bridge;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [13:0] csr_adr = '0;
  logic        csr_we = 1'b0;
  logic [7:0]  csr_dat_w = '0;
  logic [7:0]  csr_dat_r;
  logic        sink_stb = 1'b0;
  logic        sink_ack;
  logic [15:0] sink_data = '0;
  logic        src_stb;
  logic        src_ack = 1'b0;
  logic [15:0] src_data;

  int n_total = 0;
  int n_pass  = 0;

  csr_stream_bridge #(.BANK(4'h1), .DEPTH_LOG2(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .csr_adr   (csr_adr),
    .csr_we    (csr_we),
    .csr_dat_w (csr_dat_w),
    .csr_dat_r (csr_dat_r),
    .sink_stb  (sink_stb),
    .sink_ack  (sink_ack),
    .sink_data (sink_data),
    .src_stb   (src_stb),
    .src_ack   (src_ack),
    .src_data  (src_data)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        is_wr;
    logic [13:0] adr;
    logic [7:0]  dat;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [17];

  function automatic logic [13:0] adr(input logic [3:0] ofs);
    return {4'h1, 6'h00, ofs};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [7:0] d);
    csr_adr   = a;
    csr_dat_w = d;
    csr_we    = 1'b1;
    @(posedge sys_clk); #1;
    csr_we    = 1'b0;
  endtask

  task automatic csr_read(input logic [13:0] a, output logic [7:0] d);
    csr_adr = a;
    csr_we  = 1'b0;
    @(posedge sys_clk); #1;
    d = csr_dat_r;
  endtask

  task automatic rd_check(input string name, input logic [3:0] ofs, input logic [7:0] exp);
    logic [7:0] d;
    csr_read(adr(ofs), d);
    check(name, 32'(d), 32'(exp));
  endtask

  initial begin
    vecs[0]  = '{1'b0, adr(4'h0),        8'h00, 8'h05};
    vecs[1]  = '{1'b0, adr(4'h1),        8'h00, 8'h00};
    vecs[2]  = '{1'b0, adr(4'h7),        8'h00, 8'h00};
    vecs[3]  = '{1'b0, adr(4'h2),        8'h00, 8'h00};
    vecs[4]  = '{1'b0, adr(4'h3),        8'h00, 8'h00};
    vecs[5]  = '{1'b0, adr(4'h8),        8'h00, 8'h00};
    vecs[6]  = '{1'b0, {4'h1, 6'h3F, 4'h0}, 8'h00, 8'h05};
    vecs[7]  = '{1'b0, {4'h2, 6'h00, 4'h0}, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, {4'h2, 6'h00, 4'h5}, 8'h77, 8'h00};
    vecs[9]  = '{1'b0, adr(4'h7),        8'h00, 8'h00};
    vecs[10] = '{1'b1, adr(4'h4),        8'hAB, 8'h00};
    vecs[11] = '{1'b1, adr(4'h5),        8'hCD, 8'h00};
    vecs[12] = '{1'b0, adr(4'h7),        8'h00, 8'h01};
    vecs[13] = '{1'b0, adr(4'h0),        8'h00, 8'h01};
    vecs[14] = '{1'b1, adr(4'h6),        8'h04, 8'h00};
    vecs[15] = '{1'b0, adr(4'h7),        8'h00, 8'h00};
    vecs[16] = '{1'b0, adr(4'h0),        8'h00, 8'h05};

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_sink_ack", 32'(sink_ack), 32'd1);
    check("rst_src_stb", 32'(src_stb), 32'd0);
    check("rst_dat_r", 32'(csr_dat_r), 32'd0);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;

    for (int i = 0; i < 17; i++) begin
      logic [7:0] d;
      if (vecs[i].is_wr) begin
        csr_write(vecs[i].adr, vecs[i].dat);
      end else begin
        csr_read(vecs[i].adr, d);
        check($sformatf("vec[%0d]", i), 32'(d), 32'(vecs[i].exp));
      end
    end

    // Sink word into rx, peek, then pop via CTRL
    sink_data = 16'hBEEF;
    sink_stb  = 1'b1;
    @(posedge sys_clk); #1;
    sink_stb  = 1'b0;
    rd_check("rx_data_l", 4'h2, 8'hEF);
    rd_check("rx_data_h", 4'h3, 8'hBE);
    rd_check("rx_level1", 4'h1, 8'h01);
    csr_write(adr(4'h6), 8'h01);
    rd_check("rx_level0", 4'h1, 8'h00);
    rd_check("rx_data_empty", 4'h2, 8'h00);

    // One tx word with src_ack high: exactly one accepted beat
    src_ack = 1'b1;
    csr_write(adr(4'h4), 8'h34);
    csr_write(adr(4'h5), 8'h12);
    check("src_stb_beat", 32'(src_stb), 32'd1);
    check("src_data_beat", 32'(src_data), 32'h1234);
    @(posedge sys_clk); #1;
    check("src_stb_after", 32'(src_stb), 32'd0);
    src_ack = 1'b0;

    // 17 pushes into a 16-deep tx FIFO overflow
    for (int i = 0; i < 17; i++) begin
      csr_write(adr(4'h4), 8'(i));
      csr_write(adr(4'h5), 8'h50);
    end
    rd_check("tx_level_full", 4'h7, 8'h10);
    rd_check("status_ovf", 4'h0, 8'h19);
    check("tx_head", 32'(src_data), 32'h5000);
    csr_write(adr(4'h6), 8'h02);
    rd_check("status_ovf_clr", 4'h0, 8'h09);
    csr_write(adr(4'h6), 8'h04);
    rd_check("status_flushed", 4'h0, 8'h05);

    // Fill rx, then push and pop together at level 8
    for (int i = 0; i < 16; i++) begin
      sink_data = 16'(i);
      sink_stb  = 1'b1;
      @(posedge sys_clk); #1;
    end
    sink_stb = 1'b0;
    check("sink_ack_full", 32'(sink_ack), 32'd0);
    rd_check("rx_level16", 4'h1, 8'h10);
    rd_check("status_rx_full", 4'h0, 8'h06);
    for (int i = 0; i < 8; i++) csr_write(adr(4'h6), 8'h01);
    rd_check("rx_level8", 4'h1, 8'h08);
    rd_check("rx_head8", 4'h2, 8'h08);
    sink_data = 16'hAAAA;
    sink_stb  = 1'b1;
    csr_write(adr(4'h6), 8'h01);
    sink_stb  = 1'b0;
    rd_check("rx_level_pushpop", 4'h1, 8'h08);
    rd_check("rx_head9", 4'h2, 8'h09);

    // Flush with a concurrent sink push
    csr_write(adr(4'h4), 8'h11);
    csr_write(adr(4'h5), 8'h22);
    sink_data = 16'h1111;
    sink_stb  = 1'b1;
    csr_write(adr(4'h6), 8'h04);
    sink_stb  = 1'b0;
    rd_check("flush_rx_level", 4'h1, 8'h00);
    rd_check("flush_tx_level", 4'h7, 8'h00);

    // Reset asserted mid-stream
    csr_write(adr(4'h4), 8'h01);
    csr_write(adr(4'h5), 8'h02);
    csr_write(adr(4'h5), 8'h03);
    rd_check("pre_rst_status", 4'h0, 8'h01);
    check("pre_rst_src_stb", 32'(src_stb), 32'd1);
    src_ack   = 1'b1;
    sink_stb  = 1'b1;
    sink_data = 16'h5A5A;
    #2;
    sys_rst = 1'b0;
    #1;
    check("mid_rst_src_stb", 32'(src_stb), 32'd0);
    check("mid_rst_sink_ack", 32'(sink_ack), 32'd1);
    check("mid_rst_dat_r", 32'(csr_dat_r), 32'd0);
    @(posedge sys_clk); #2;
    sink_stb = 1'b0;
    src_ack  = 1'b0;
    sys_rst  = 1'b1;
    @(posedge sys_clk); #1;
    check("post_rst_src_stb", 32'(src_stb), 32'd0);
    rd_check("post_rst_status", 4'h0, 8'h05);
    rd_check("post_rst_rx_level", 4'h1, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
